// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake bundle between two UART producers, the arbiter and Uart.
// Lock fields exist only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic       req0_lock;
  logic       req1_lock;
`endif
  logic       uart_in_valid;
  logic [7:0] uart_in_data;
  logic       uart_in_ready;

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  uart_in_ready,
`ifdef UART_TX_ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    output req0_ready, req1_ready,
    output uart_in_valid, uart_in_data
  );

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output uart_in_ready,
`ifdef UART_TX_ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    input  req0_ready, req1_ready,
    input  uart_in_valid, uart_in_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART tx byte port between two producers.
// Optional message lock with idle timeout when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter
`ifdef UART_TX_ARB_LOCK_EN
#(
  parameter int LOCK_TIMEOUT = 255
)
`endif
(
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus,
  output logic              locked,
  output logic              last_grant
);

  logic       out_v;
  logic [7:0] out_d;
  logic       v0;
  logic       v1;
  logic       drain;
  logic       slot;
  logic       any;
  logic       win;
  logic       xfer;

  assign v0    = bus.req0_valid;
  assign v1    = bus.req1_valid;
  assign drain = out_v && bus.uart_in_ready;
  assign slot  = !reset && (!out_v || drain);
  assign xfer  = slot && any;

  assign bus.req0_ready    = xfer && !win;
  assign bus.req1_ready    = xfer && win;
  assign bus.uart_in_valid = out_v;
  assign bus.uart_in_data  = out_d;

`ifdef UART_TX_ARB_LOCK_EN
  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_e;

  localparam logic [7:0] TO = 8'(LOCK_TIMEOUT);

  lock_e      state_q;
  lock_e      state_d;
  logic       owner_q;
  logic       owner_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic       lock_w;

  assign locked  = (state_q == LOCKED);
  assign lock_w  = win ? bus.req1_lock : bus.req0_lock;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    any = 1'b0;
    win = 1'b0;
    if (state_q == LOCKED) begin
      any = owner_q ? v1 : v0;
      win = owner_q;
    end else if (v0 && v1) begin
      any = 1'b1;
      win = !last_grant;
    end else begin
      any = v0 || v1;
      win = v1;
    end
  end

  // Release is registered, so the non-owner sees it one cycle after the
  // count reaches the limit.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        if (xfer && lock_w) begin
          state_d = LOCKED;
          owner_d = win;
          cnt_d   = 8'd0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = 8'd0;
          if (!lock_w) state_d = UNLOCKED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) state_d = UNLOCKED;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      owner_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign locked = 1'b0;

  always_comb begin
    any = v0 || v1;
    win = (v0 && v1) ? !last_grant : v1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v      <= 1'b0;
      out_d      <= 8'd0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      out_v      <= 1'b1;
      out_d      <= win ? bus.req1_data : bus.req0_data;
      last_grant <= win;
    end else if (drain) begin
      out_v      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected
// bytes, a negedge monitor pops them as the UART port drains.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic locked;
  logic last_grant;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  uart_tx_arbiter_if bus();

`ifdef UART_TX_ARB_LOCK_EN
  uart_tx_arbiter #(.LOCK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .locked(locked), .last_grant(last_grant));
`else
  uart_tx_arbiter dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .locked(locked), .last_grant(last_grant));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.uart_in_valid && bus.uart_in_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_extra got %0h want none", bus.uart_in_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.uart_in_data !== mon_e) begin
          errors++;
          $display("FAIL mon_byte got %0h want %0h", bus.uart_in_data, mon_e);
        end
      end
    end
  end

  initial begin
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'h99;
    bus.req1_valid = 1'b0;
    bus.req1_data = 8'h00;
    bus.uart_in_ready = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req0_lock = 1'b0;
    bus.req1_lock = 1'b0;
`endif
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    chk("rst_valid", bus.uart_in_valid, 1'b0);
    chk("rst_data", bus.uart_in_data, 8'h00);
    chk("rst_locked", locked, 1'b0);
    chk("rst_last_grant", last_grant, 1'b1);
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    tick();

    // Round-robin under contention
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'h41;
    bus.req1_valid = 1'b1;
    bus.req1_data = 8'h42;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ready", {bus.req0_ready, bus.req1_ready},
          (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_out_valid", bus.uart_in_valid, (i == 0) ? 1'b0 : 1'b1);
      exp_q.push_back((i % 2 == 0) ? 8'h41 : 8'h42);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_last_grant", last_grant, 1'b1);
    repeat (2) tick();

    // Back-pressure hold
    bus.uart_in_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready0", bus.req0_ready, (i == 0) ? 1'b1 : 1'b0);
      if (i == 0) exp_q.push_back(8'h55);
      else chk("stall_hold", {bus.uart_in_valid, bus.uart_in_data}, 9'h155);
      tick();
      if (i == 0) bus.req0_data = 8'h56;
    end
    bus.uart_in_ready = 1'b1;
    @(negedge clk);
    chk("stall_resume", bus.req0_ready, 1'b1);
    exp_q.push_back(8'h56);
    tick();
    bus.req0_valid = 1'b0;
    repeat (2) tick();

`ifdef UART_TX_ARB_LOCK_EN
    // Locked multi-byte message from req1
    bus.req1_valid = 1'b1;
    bus.req1_data = 8'h10;
    bus.req1_lock = 1'b1;
    @(negedge clk);
    chk("lk0_ready1", bus.req1_ready, 1'b1);
    chk("lk0_locked", locked, 1'b0);
    exp_q.push_back(8'h10);
    tick();
    bus.req1_data = 8'h11;
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'hA0;
    @(negedge clk);
    chk("lk1_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
    chk("lk1_locked", locked, 1'b1);
    exp_q.push_back(8'h11);
    tick();
    bus.req1_data = 8'h12;
    bus.req1_lock = 1'b0;
    @(negedge clk);
    chk("lk2_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
    chk("lk2_locked", locked, 1'b1);
    exp_q.push_back(8'h12);
    tick();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("lk3_ready0", bus.req0_ready, 1'b1);
    chk("lk3_locked", locked, 1'b0);
    exp_q.push_back(8'hA0);
    tick();
    bus.req0_valid = 1'b0;
    repeat (2) tick();

    // Lock timeout release
    bus.req1_valid = 1'b1;
    bus.req1_data = 8'h20;
    bus.req1_lock = 1'b1;
    @(negedge clk);
    chk("to_ready1", bus.req1_ready, 1'b1);
    exp_q.push_back(8'h20);
    tick();
    bus.req1_valid = 1'b0;
    bus.req1_lock = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'h30;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("to_ready0", bus.req0_ready, (k == 5) ? 1'b1 : 1'b0);
      chk("to_locked", locked, (k == 5) ? 1'b0 : 1'b1);
      if (k == 5) exp_q.push_back(8'h30);
      tick();
    end
    bus.req0_valid = 1'b0;
    repeat (2) tick();
`endif

    // Reset while a byte is parked in the output register
    bus.uart_in_ready = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data = 8'h77;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req1_lock = 1'b1;
`endif
    @(negedge clk);
    chk("mr_ready1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    bus.req1_lock = 1'b0;
`endif
    @(negedge clk);
    chk("mr_parked", bus.uart_in_valid, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
    chk("mr_locked", locked, 1'b1);
`endif
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.uart_in_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data = 8'h61;
    bus.req1_valid = 1'b1;
    bus.req1_data = 8'h62;
    @(negedge clk);
    chk("mr_valid", bus.uart_in_valid, 1'b0);
    chk("mr_locked_clr", locked, 1'b0);
    chk("mr_last_grant", last_grant, 1'b1);
    chk("mr_first", {bus.req0_ready, bus.req1_ready}, 2'b10);
    exp_q.push_back(8'h61);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) tick();

    // Single-requester stream at full rate
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.req1_data = 8'(i);
      @(negedge clk);
      chk("stream_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
      exp_q.push_back(8'(i));
      tick();
    end
    bus.req1_valid = 1'b0;

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
